// File: rtl/shift_reg_pkg.sv
// rtl/shift_reg_pkg.sv - mode and burst-FSM encodings shared by the universal shift register
package shift_reg_pkg;

    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_SHR  = 3'b001;
    localparam logic [2:0] MODE_SHL  = 3'b010;
    localparam logic [2:0] MODE_ROR  = 3'b011;
    localparam logic [2:0] MODE_ROL  = 3'b100;
    localparam logic [2:0] MODE_LOAD = 3'b101;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } burst_state_t;

    // Only shift/rotate modes consume ticks; anything else makes a burst empty.
    function automatic logic is_shift_mode(input logic [2:0] m);
        return (m == MODE_SHR) || (m == MODE_SHL) || (m == MODE_ROR) || (m == MODE_ROL);
    endfunction

endpackage

// File: rtl/tick_gen.sv
// rtl/tick_gen.sv - free-running divider producing a 1-cycle tick every CLK_HZ/DIV cycles
module tick_gen #(
    parameter int CLK_HZ = 100_000_000,
    parameter int DIV    = 4
) (
    input  logic clk_100MHz,
    input  logic rst,
    output logic tick
);

    localparam int TP = CLK_HZ / DIV;
    localparam int CW = (TP > 2) ? $clog2(TP) : 1;
    localparam logic [CW-1:0] LAST = CW'(TP - 1);

    logic [CW-1:0] cnt;

    assign tick = (cnt == LAST);

    always_ff @(posedge clk_100MHz) begin
        if (rst) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/universal_shift_register.sv
// rtl/universal_shift_register.sv - tick-paced shift/rotate/load register with counted bursts
module universal_shift_register
    import shift_reg_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int DIV    = 4,
    parameter int CLK_HZ = 100_000_000
) (
    input  logic                         clk_100MHz,
    input  logic                         rst,
    input  logic [2:0]                   mode,
    input  logic                         serial_in,
    input  logic [WIDTH-1:0]             load_data,
    input  logic                         start,
    input  logic [$clog2(WIDTH+1)-1:0]   burst_len,
    output logic [WIDTH-1:0]             parallel_out,
    output logic                         serial_out,
    output logic                         busy,
    output logic                         done
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LEN_MAX = CW'(WIDTH);

    logic tick;

    tick_gen #(
        .CLK_HZ (CLK_HZ),
        .DIV    (DIV)
    ) u_tick_gen (
        .clk_100MHz (clk_100MHz),
        .rst        (rst),
        .tick       (tick)
    );

    burst_state_t     state, state_nx;
    logic [WIDTH-1:0] r, r_nx;
    logic             ser_nx;
    logic             done_nx;
    logic [2:0]       lat_mode, lat_mode_nx;
    logic [CW-1:0]    count, count_nx;

    logic [2:0]       op_mode;
    logic [WIDTH-1:0] op_r;
    logic             op_bit;
    logic [CW-1:0]    len_sat;

    assign busy    = (state == ST_RUN);
    assign op_mode = (state == ST_RUN) ? lat_mode : mode;
    assign len_sat = (burst_len > LEN_MAX) ? LEN_MAX : burst_len;

    always_comb begin
        op_r   = r;
        op_bit = serial_out;
        case (op_mode)
            MODE_SHR: begin
                op_r   = {serial_in, r[WIDTH-1:1]};
                op_bit = r[0];
            end
            MODE_SHL: begin
                op_r   = {r[WIDTH-2:0], serial_in};
                op_bit = r[WIDTH-1];
            end
            MODE_ROR: begin
                op_r   = {r[0], r[WIDTH-1:1]};
                op_bit = r[0];
            end
            MODE_ROL: begin
                op_r   = {r[WIDTH-2:0], r[WIDTH-1]};
                op_bit = r[WIDTH-1];
            end
            default: ;
        endcase
    end

    always_comb begin
        state_nx    = state;
        r_nx        = r;
        ser_nx      = serial_out;
        lat_mode_nx = lat_mode;
        count_nx    = count;
        done_nx     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    // A burst of a non-shifting mode is empty: it just produces done.
                    lat_mode_nx = mode;
                    count_nx    = is_shift_mode(mode) ? len_sat : '0;
                    state_nx    = ST_RUN;
                end else if (mode == MODE_LOAD) begin
                    r_nx = load_data;
                end else if (tick && is_shift_mode(mode)) begin
                    r_nx   = op_r;
                    ser_nx = op_bit;
                end
            end
            ST_RUN: begin
                if (count == '0) begin
                    state_nx = ST_IDLE;
                    done_nx  = 1'b1;
                end else if (tick) begin
                    r_nx     = op_r;
                    ser_nx   = op_bit;
                    count_nx = count - CW'(1);
                    if (count == CW'(1)) begin
                        state_nx = ST_IDLE;
                        done_nx  = 1'b1;
                    end
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_100MHz) begin
        if (rst) begin
            state        <= ST_IDLE;
            r            <= '0;
            parallel_out <= '0;
            serial_out   <= 1'b0;
            done         <= 1'b0;
            lat_mode     <= MODE_HOLD;
            count        <= '0;
        end else begin
            state        <= state_nx;
            r            <= r_nx;
            parallel_out <= r;
            serial_out   <= ser_nx;
            done         <= done_nx;
            lat_mode     <= lat_mode_nx;
            count        <= count_nx;
        end
    end

endmodule
